// File: rtl/aes_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_req_arbiter
// Purpose  : Round-robin scheduler sharing one AES_top core among NUM_REQ
//            requesters; optional RUN watchdog via AES_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aes_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                   AES_clk,
   input  logic                   AES_rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*128-1:0] req_data,
   input  logic [NUM_REQ*128-1:0] req_key,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [127:0]           rsp_data,
   output logic                   rsp_err,
   output logic                   core_en,
   output logic [127:0]           core_data_in,
   output logic [127:0]           core_key_in,
   input  logic [127:0]           core_data_out,
   input  logic                   core_data_out_valid,
   output logic                   busy
);

   localparam logic [PTR_W:0]   c_num_req = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] c_last    = PTR_W'(NUM_REQ-1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || PTR_W != $clog2(NUM_REQ) || TIMEOUT < 1) begin : g_param_check
      $error("aes_req_arbiter: illegal NUM_REQ/PTR_W/TIMEOUT combination");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_RESP = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t             r_state;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [PTR_W-1:0]   r_owner;
   logic               r_core_en;
   logic [127:0]       r_core_data_in;
   logic [127:0]       r_core_key_in;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [127:0]       r_rsp_data;

   logic               w_found;
   logic [PTR_W-1:0]   w_winner;
   logic [PTR_W-1:0]   w_next_ptr;
   logic [PTR_W:0]     w_sum;
   logic [NUM_REQ-1:0] w_owner_onehot;

`ifdef AES_ARB_TIMEOUT_EN
   localparam int               c_cnt_w   = $clog2(TIMEOUT+1);
   localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT-1);
   logic               r_rsp_err;
   logic [c_cnt_w-1:0] r_cnt;
`endif

   // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_sum    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
         if (w_sum >= c_num_req) begin
            w_sum = w_sum - c_num_req;
         end
         if (!w_found && req_valid[w_sum[PTR_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_sum[PTR_W-1:0];
         end
      end
   end

   assign w_next_ptr     = (w_winner == c_last) ? '0 : w_winner + 1'b1;
   assign w_owner_onehot = NUM_REQ'(1) << r_owner;

   assign req_ready = (r_state == ST_IDLE && w_found) ? (NUM_REQ'(1) << w_winner) : '0;

   always_ff @(posedge AES_clk or negedge AES_rst_n) begin
      if (!AES_rst_n) begin
         r_state        <= ST_IDLE;
         r_rr_ptr       <= '0;
         r_owner        <= '0;
         r_core_en      <= 1'b0;
         r_core_data_in <= '0;
         r_core_key_in  <= '0;
         r_rsp_valid    <= '0;
         r_rsp_data     <= '0;
`ifdef AES_ARB_TIMEOUT_EN
         r_rsp_err      <= 1'b0;
         r_cnt          <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_core_data_in <= req_data[w_winner*128 +: 128];
                  r_core_key_in  <= req_key[w_winner*128 +: 128];
                  r_owner        <= w_winner;
                  r_rr_ptr       <= w_next_ptr;
                  r_core_en      <= 1'b1;
                  r_state        <= ST_RUN;
`ifdef AES_ARB_TIMEOUT_EN
                  r_cnt          <= '0;
`endif
               end
            end
            ST_RUN: begin
               // A core result on the final watchdog cycle still counts as success.
               if (core_data_out_valid) begin
                  r_rsp_data  <= core_data_out;
                  r_core_en   <= 1'b0;
                  r_rsp_valid <= w_owner_onehot;
                  r_state     <= ST_RESP;
`ifdef AES_ARB_TIMEOUT_EN
                  r_rsp_err   <= 1'b0;
               end else if (r_cnt == c_cnt_max) begin
                  r_rsp_data  <= '0;
                  r_rsp_err   <= 1'b1;
                  r_core_en   <= 1'b0;
                  r_rsp_valid <= w_owner_onehot;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt       <= r_cnt + 1'b1;
`endif
               end
            end
            ST_RESP: begin
               if (rsp_ready[r_owner]) begin
                  r_rsp_valid <= '0;
                  r_state     <= ST_GAP;
               end
            end
            ST_GAP: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign core_en      = r_core_en;
   assign core_data_in = r_core_data_in;
   assign core_key_in  = r_core_key_in;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_data     = r_rsp_data;
   assign busy         = (r_state != ST_IDLE);
`ifdef AES_ARB_TIMEOUT_EN
   assign rsp_err      = r_rsp_err;
`else
   assign rsp_err      = 1'b0;
`endif

endmodule
`default_nettype wire
